// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 8-bit read and write engines:
// FSM state encoding, default LCD timing in fabric cycles, and RS encodings.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    GAP,
    EVAL
  } lcd_state_t;

  // Defaults for a 125 MHz fabric clock
  localparam int LCD_AS_CYC    = 8;
  localparam int LCD_PW_CYC    = 60;
  localparam int LCD_HOLD_CYC  = 8;
  localparam int LCD_GAP_CYC   = 64;
  localparam int LCD_MAX_POLLS = 1024;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  function automatic int max_of4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_read_engine_if.sv
// Host-side request/result handshake of the LCD read engine.
interface lcd_read_if;
  logic       req;
  logic       rs_sel;
  logic       poll;
  logic       ready;
  logic       done;
  logic [7:0] data;
  logic       busy_flag;
  logic [6:0] addr;
  logic       timeout;

  modport master (
    output req, rs_sel, poll,
    input  ready, done, data, busy_flag, addr, timeout
  );

  modport slave (
    input  req, rs_sel, poll,
    output ready, done, data, busy_flag, addr, timeout
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load
// of N-1 on state entry yields a phase exactly N cycles long.
module lcd_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/lcd_read_engine.sv
// HD44780 8-bit read-cycle engine: status/address or data read, with optional
// busy-flag polling. All LCD timing is counted in fabric clock cycles.
module lcd_read_engine
  import lcd_pkg::*;
#(
  parameter int AS_CYC    = LCD_AS_CYC,
  parameter int PW_CYC    = LCD_PW_CYC,
  parameter int HOLD_CYC  = LCD_HOLD_CYC,
  parameter int GAP_CYC   = LCD_GAP_CYC,
  parameter int MAX_POLLS = LCD_MAX_POLLS
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lcd_read_if.slave  host,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  input  logic [7:0] lcd_db_i
);

  localparam int CNT_W  = $clog2(max_of4(AS_CYC, PW_CYC, HOLD_CYC, GAP_CYC)) + 1;
  localparam int POLL_W = $clog2(MAX_POLLS) + 1;

  localparam logic [CNT_W-1:0]  AS_LD     = CNT_W'(AS_CYC - 1);
  localparam logic [CNT_W-1:0]  PW_LD     = CNT_W'(PW_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);

  lcd_state_t        state;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tc;
  logic              poll_q;
  logic              poll_again;
  logic [POLL_W-1:0] poll_cnt;
  logic [7:0]        sample;
  logic              ready_q, done_q, timeout_q, bf_q;
  logic [7:0]        data_q;
  logic [6:0]        addr_q;

  lcd_phase_timer #(.W(CNT_W)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  // poll_cnt < MAX_POLLS-1 is the same test as poll_cnt+1 < MAX_POLLS
  assign poll_again = poll_q && sample[7] && (poll_cnt < POLL_LAST);

  // Reload the phase timer on every entry into a timed state
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:  if (host.req)  begin tmr_load = 1'b1; tmr_val = AS_LD;   end
      SETUP: if (tc)        begin tmr_load = 1'b1; tmr_val = PW_LD;   end
      PULSE: if (tc)        begin tmr_load = 1'b1; tmr_val = HOLD_LD; end
      HOLD:  if (tc)        begin tmr_load = 1'b1; tmr_val = GAP_LD;  end
      EVAL:  if (poll_again) begin tmr_load = 1'b1; tmr_val = AS_LD;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
      bf_q      <= 1'b0;
      addr_q    <= '0;
      lcd_rs_o  <= RS_INSTR;
      lcd_rw_o  <= 1'b0;
      lcd_e_o   <= 1'b0;
      poll_q    <= 1'b0;
      poll_cnt  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q  <= 1'b1;
          lcd_rw_o <= 1'b0;
          lcd_e_o  <= 1'b0;
          if (host.req) begin
            lcd_rs_o <= host.rs_sel;
            lcd_rw_o <= 1'b1;
            poll_q   <= host.poll && (host.rs_sel != RS_DATA);
            poll_cnt <= '0;
            ready_q  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: if (tc) begin
          lcd_e_o <= 1'b1;
          state   <= PULSE;
        end
        // The bus has settled well before the last E-high cycle
        PULSE: if (tc) begin
          lcd_e_o <= 1'b0;
          sample  <= lcd_db_i;
          state   <= HOLD;
        end
        HOLD: if (tc) state <= GAP;
        GAP:  if (tc) state <= EVAL;
        EVAL: begin
          if (poll_again) begin
            poll_cnt <= poll_cnt + POLL_W'(1);
            state    <= SETUP;
          end else begin
            data_q <= sample;
            if (lcd_rs_o == RS_INSTR) begin
              bf_q   <= sample[7];
              addr_q <= sample[6:0];
            end
            timeout_q <= poll_q && sample[7];
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            lcd_rw_o  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.ready     = ready_q;
  assign host.done      = done_q;
  assign host.data      = data_q;
  assign host.busy_flag = bf_q;
  assign host.addr      = addr_q;
  assign host.timeout   = timeout_q;

endmodule
